// File: rtl/pipe_stage_skid_pkg.sv
// ============================================================================
// Module   : pipe_stage_skid_pkg
// Brief    : Occupancy encodings and slot command type for pipe_stage_skid.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_stage_skid_pkg;

   localparam logic [1:0] c_st_empty = 2'd0;
   localparam logic [1:0] c_st_one   = 2'd1;
   localparam logic [1:0] c_st_two   = 2'd2;

   typedef struct packed {
      logic load;
      logic kill;
   } slot_cmd_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_slot.sv
// ============================================================================
// Module   : pipe_slot
// Brief    : One pipeline entry: valid flag, payload and kill-able control bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  slot_cmd_t         i_cmd,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   // Kill drops valid and control but leaves the payload untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (i_cmd.kill) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else if (i_cmd.load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ctrl  <= i_ctrl;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Parametrised inter-stage register with optional 2-entry skid,
//            flush and saturating stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_accept;
   logic              w_pop;
   slot_cmd_t         w_head_cmd;
   slot_cmd_t         w_skid_cmd;
   logic              w_head_from_skid;

   logic              w_head_valid;
   logic [DATA_W-1:0] w_head_data;
   logic [CTRL_W-1:0] w_head_ctrl;
   logic [DATA_W-1:0] w_head_d_data;
   logic [CTRL_W-1:0] w_head_d_ctrl;

   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_data;
   logic [CTRL_W-1:0] w_skid_ctrl;

   // With the skid, ready depends only on state; without it, ready looks through to out_ready.
   assign in_ready = flush | ((SKID != 0) ? (r_state != c_st_two)
                                          : ((r_state == c_st_empty) | out_ready));
   assign w_accept = in_valid & in_ready;
   assign w_pop    = w_head_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_empty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = c_st_empty;
      end else begin
         case (r_state)
            c_st_empty: if (w_accept) w_state_nxt = c_st_one;
            c_st_one: begin
               if (w_accept && !w_pop) begin
                  w_state_nxt = c_st_two;
               end else if (!w_accept && w_pop) begin
                  w_state_nxt = c_st_empty;
               end
            end
            c_st_two:   if (w_pop) w_state_nxt = c_st_one;
            default:    w_state_nxt = c_st_empty;
         endcase
      end
   end

   always_comb begin
      w_head_cmd       = '0;
      w_skid_cmd       = '0;
      w_head_from_skid = 1'b0;
      if (flush) begin
         w_head_cmd.kill = 1'b1;
         w_skid_cmd.kill = 1'b1;
      end else begin
         case (r_state)
            c_st_empty: w_head_cmd.load = w_accept;
            c_st_one: begin
               if (w_accept && w_pop) begin
                  w_head_cmd.load = 1'b1;
               end else if (w_accept) begin
                  w_skid_cmd.load = 1'b1;
               end else if (w_pop) begin
                  w_head_cmd.kill = 1'b1;
               end
            end
            c_st_two: begin
               if (w_pop && w_skid_valid) begin
                  w_head_cmd.load  = 1'b1;
                  w_head_from_skid = 1'b1;
                  w_skid_cmd.kill  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_head_d_data = w_head_from_skid ? w_skid_data : in_data;
   assign w_head_d_ctrl = w_head_from_skid ? w_skid_ctrl : in_ctrl;

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_head (
      .clk     (clk),
      .rst     (rst),
      .i_cmd   (w_head_cmd),
      .i_data  (w_head_d_data),
      .i_ctrl  (w_head_d_ctrl),
      .o_valid (w_head_valid),
      .o_data  (w_head_data),
      .o_ctrl  (w_head_ctrl)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
         ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .i_cmd   (w_skid_cmd),
            .i_data  (in_data),
            .i_ctrl  (in_ctrl),
            .o_valid (w_skid_valid),
            .o_data  (w_skid_data),
            .o_ctrl  (w_skid_ctrl)
         );
      end else begin : g_no_skid
         assign w_skid_valid = 1'b0;
         assign w_skid_data  = '0;
         assign w_skid_ctrl  = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_head_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid = w_head_valid;
   assign out_data  = w_head_data;
   assign out_ctrl  = w_head_ctrl;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Bench for pipe_stage_skid, SKID=0 and SKID=1 instances side by side.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_stage_skid;

   localparam int DW     = 16;
   localparam int CW     = 8;
   localparam int NW     = 4;
   localparam int CNTMAX = 15;
   localparam int NVEC   = 31;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst       = 1'b1;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b1;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic [CW-1:0] in_ctrl   = '0;

   logic          in_ready0, out_valid0, in_ready1, out_valid1;
   logic [DW-1:0] out_data0, out_data1;
   logic [CW-1:0] out_ctrl0, out_ctrl1;
   logic [1:0]    occ0, occ1;
   logic [NW-1:0] sc0, sc1;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_ctrl(out_ctrl0), .occupancy(occ0), .stall_cnt(sc0));

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_ctrl(out_ctrl1), .occupancy(occ1), .stall_cnt(sc1));

   int total = 0;
   int bad   = 0;

   // Reference: a FIFO of up to CAP entries per instance, CAP = 1 or 2.
   logic [DW-1:0] md    [2][2];
   logic [CW-1:0] mc    [2][2];
   int            mn    [2];
   int            mcnt  [2];
   logic [DW-1:0] mlast [2];
   bit            model_ok = 1'b0;

   typedef struct packed {
      logic          chk;
      logic          r, f, iv;
      logic [DW-1:0] id;
      logic [CW-1:0] ic;
      logic          ordy;
      logic          e_rdy, e_ov;
      logic [DW-1:0] e_od;
      logic [CW-1:0] e_oc;
      logic [1:0]    e_occ;
      logic [NW-1:0] e_sc;
   } vec_t;

   vec_t tbl [NVEC];

   function automatic vec_t mk(int c, int r, int f, int iv, int id, int ic, int ordy,
                               int erdy, int eov, int eod, int eoc, int eocc, int esc);
      vec_t v;
      v.chk = 1'(c);  v.r = 1'(r);  v.f = 1'(f);  v.iv = 1'(iv);
      v.id = DW'(id); v.ic = CW'(ic); v.ordy = 1'(ordy);
      v.e_rdy = 1'(erdy); v.e_ov = 1'(eov); v.e_od = DW'(eod); v.e_oc = CW'(eoc);
      v.e_occ = 2'(eocc); v.e_sc = NW'(esc);
      return v;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] act(input int d, input int f);
      logic [31:0] a;
      a = '0;
      case (f)
         0: a = (d == 0) ? 32'(in_ready0)  : 32'(in_ready1);
         1: a = (d == 0) ? 32'(out_valid0) : 32'(out_valid1);
         2: a = (d == 0) ? 32'(out_data0)  : 32'(out_data1);
         3: a = (d == 0) ? 32'(out_ctrl0)  : 32'(out_ctrl1);
         4: a = (d == 0) ? 32'(occ0)       : 32'(occ1);
         default: a = (d == 0) ? 32'(sc0)  : 32'(sc1);
      endcase
      return a;
   endfunction

   function automatic logic exp_ready(input int d);
      if (flush) return 1'b1;
      if (d == 1) return (mn[d] < 2);
      return (mn[d] == 0) || out_ready;
   endfunction

   task automatic drive(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                        input logic [CW-1:0] ic, input logic ordy);
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_data = id; in_ctrl = ic; out_ready = ordy;
      #1;
   endtask

   task automatic model_check();
      if (model_ok) begin
         for (int d = 0; d < 2; d++) begin
            chk("in_ready",  d, act(d, 0), 32'(exp_ready(d)));
            chk("out_valid", d, act(d, 1), (mn[d] > 0) ? 32'd1 : 32'd0);
            chk("out_data",  d, act(d, 2), (mn[d] > 0) ? 32'(md[d][0]) : 32'(mlast[d]));
            chk("out_ctrl",  d, act(d, 3), (mn[d] > 0) ? 32'(mc[d][0]) : 32'd0);
            chk("occupancy", d, act(d, 4), 32'(mn[d]));
            chk("stall_cnt", d, act(d, 5), 32'(mcnt[d]));
         end
      end
   endtask

   task automatic model_advance();
      for (int d = 0; d < 2; d++) begin
         logic rdy;
         rdy = exp_ready(d);
         if (rst) begin
            mn[d] = 0; mcnt[d] = 0; mlast[d] = '0;
         end else if (flush) begin
            mn[d] = 0;
         end else begin
            if (mn[d] > 0 && !out_ready && mcnt[d] < CNTMAX) mcnt[d]++;
            if (mn[d] > 0 && out_ready) begin
               md[d][0] = md[d][1]; mc[d][0] = mc[d][1]; mn[d]--;
            end
            if (in_valid && rdy && mn[d] < 2) begin
               md[d][mn[d]] = in_data; mc[d][mn[d]] = in_ctrl; mn[d]++;
            end
         end
         if (mn[d] > 0) mlast[d] = md[d][0];
      end
      if (rst) model_ok = 1'b1;
   endtask

   task automatic cycle(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                        input logic [CW-1:0] ic, input logic ordy);
      drive(r, f, iv, id, ic, ordy);
      model_check();
      model_advance();
   endtask

   initial begin
      int bias;
      // Directed sequence; expectations are for the SKID=1 instance.
      tbl[0]  = mk(0, 1,0,1,'h55,'h11,0,  0,0,0,0,0,0);
      tbl[1]  = mk(1, 1,0,1,'h55,'h11,0,  1,0,0,0,0,0);
      tbl[2]  = mk(1, 1,0,1,'h55,'h11,0,  1,0,0,0,0,0);
      tbl[3]  = mk(1, 0,0,0,0,0,1,        1,0,0,0,0,0);
      for (int k = 1; k <= 8; k++)
         tbl[3+k] = mk(1, 0,0,1,k,k,1, 1, (k > 1) ? 1 : 0, (k > 1) ? k-1 : 0,
                       (k > 1) ? k-1 : 0, (k > 1) ? 1 : 0, 0);
      tbl[12] = mk(1, 0,0,0,0,0,1,          1,1,8,8,1,0);
      tbl[13] = mk(1, 0,0,0,0,0,1,          1,0,8,0,0,0);
      tbl[14] = mk(1, 0,0,1,'hA,'hA,0,      1,0,8,0,0,0);
      tbl[15] = mk(1, 0,0,1,'hB,'hB,0,      1,1,'hA,'hA,1,0);
      tbl[16] = mk(1, 0,0,1,'hC,'hC,0,      0,1,'hA,'hA,2,1);
      tbl[17] = mk(1, 0,0,1,'hC,'hC,0,      0,1,'hA,'hA,2,2);
      tbl[18] = mk(1, 0,0,1,'hC,'hC,1,      0,1,'hA,'hA,2,3);
      tbl[19] = mk(1, 0,0,1,'hC,'hC,1,      1,1,'hB,'hB,1,3);
      tbl[20] = mk(1, 0,0,0,0,0,1,          1,1,'hC,'hC,1,3);
      tbl[21] = mk(1, 0,0,0,0,0,0,          1,0,'hC,0,0,3);
      tbl[22] = mk(1, 0,0,1,'h21,'h21,0,    1,0,'hC,0,0,3);
      tbl[23] = mk(1, 0,0,1,'h22,'h22,0,    1,1,'h21,'h21,1,3);
      tbl[24] = mk(1, 0,1,1,'h33,'hFF,0,    1,1,'h21,'h21,2,4);
      tbl[25] = mk(1, 0,0,0,0,0,1,          1,0,'h21,0,0,4);
      tbl[26] = mk(1, 0,0,1,'h41,'h41,1,    1,0,'h21,0,0,4);
      tbl[27] = mk(1, 0,0,1,'h42,'h42,1,    1,1,'h41,'h41,1,4);
      tbl[28] = mk(1, 0,0,1,'h43,'h43,0,    1,1,'h42,'h42,1,4);
      tbl[29] = mk(1, 1,0,1,'h44,'h44,0,    0,1,'h42,'h42,2,5);
      tbl[30] = mk(1, 0,0,0,0,0,0,          1,0,0,0,0,0);

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].id, tbl[i].ic, tbl[i].ordy);
         if (tbl[i].chk) begin
            chk("vec_in_ready",  i, act(1, 0), 32'(tbl[i].e_rdy));
            chk("vec_out_valid", i, act(1, 1), 32'(tbl[i].e_ov));
            chk("vec_out_data",  i, act(1, 2), 32'(tbl[i].e_od));
            chk("vec_out_ctrl",  i, act(1, 3), 32'(tbl[i].e_oc));
            chk("vec_occupancy", i, act(1, 4), 32'(tbl[i].e_occ));
            chk("vec_stall_cnt", i, act(1, 5), 32'(tbl[i].e_sc));
         end
         model_check();
         model_advance();
      end

      // Saturation: one entry held for 20 stalled cycles.
      cycle(1'b0, 1'b0, 1'b1, 16'h0077, 8'h07, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      chk("sat_stall_cnt", 0, act(0, 5), 32'd15);
      chk("sat_stall_cnt", 1, act(1, 5), 32'd15);
      chk("sat_max_occ",   0, act(0, 4), 32'd1);
      model_check();
      model_advance();

      // Randomised traffic with shifting backpressure.
      bias = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) bias = (n / 200) % 3 == 0 ? 90 : ((n / 200) % 3 == 1 ? 20 : 50);
         cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
               ($urandom_range(0, 99) < bias));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
